// File: rtl/mantissa_normalizer_if.sv
// Valid/ready bus between the adder result stage, the normalizer and the rounding stage.
interface mantissa_normalizer_if #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned LZC_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sign;
    logic              out_zero;
    logic [LZC_W-1:0]  out_lzc;

    // Producer of un-normalized results and consumer of normalized ones
    modport master (
        output in_valid, in_mant, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_lzc
    );

    // The normalizer itself
    modport slave (
        input  in_valid, in_mant, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_lzc
    );
endinterface

// File: rtl/mantissa_normalizer.sv
// Two-stage left-shift normalizer: leading-zero count, then shift and exponent adjust.
// Underflow handling: NORM_DENORM_EN defined gives gradual underflow, otherwise flush to zero.
module mantissa_normalizer #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned LZC_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mantissa_normalizer_if.slave  bus
);
    localparam int unsigned CMP_W = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    logic              r_s1_valid;
    logic [MANT_W-1:0] r_s1_mant;
    logic [EXP_W-1:0]  r_s1_exp;
    logic              r_s1_sign;
    logic [LZC_W-1:0]  r_s1_lzc;

    logic              r_s2_valid;
    logic [MANT_W-1:0] r_out_mant;
    logic [EXP_W-1:0]  r_out_exp;
    logic              r_out_sign;
    logic              r_out_zero;
    logic [LZC_W-1:0]  r_out_lzc;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [LZC_W-1:0]  w_lzc;
    logic [CMP_W-1:0]  w_exp_ext;
    logic [CMP_W-1:0]  w_lzc_ext;
    logic [MANT_W-1:0] w_n_mant;
    logic [EXP_W-1:0]  w_n_exp;
    logic              w_n_zero;
    logic [LZC_W-1:0]  w_n_lzc;
`ifdef NORM_DENORM_EN
    logic [LZC_W-1:0]  w_dn_shift;
`endif

    // Stall propagates back combinationally; there is no skid buffer
    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    // Leading-zero count; the highest set bit wins, all-zero gives MANT_W
    always_comb begin
        w_lzc = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (bus.in_mant[i]) begin
                w_lzc = LZC_W'(MANT_W - 1 - i);
            end
        end
    end

    // Stage 1: capture operands and their leading-zero count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_exp   <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_lzc   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_mant <= bus.in_mant;
                r_s1_exp  <= bus.in_exp;
                r_s1_sign <= bus.in_sign;
                r_s1_lzc  <= w_lzc;
            end
        end
    end

    assign w_exp_ext = CMP_W'(r_s1_exp);
    assign w_lzc_ext = CMP_W'(r_s1_lzc);

    // Stage 2 datapath: normal shift, zero, or underflow
    always_comb begin
        w_n_mant = '0;
        w_n_exp  = '0;
        w_n_zero = 1'b0;
        w_n_lzc  = '0;
`ifdef NORM_DENORM_EN
        w_dn_shift = (r_s1_exp != '0) ? LZC_W'(r_s1_exp - EXP_ONE) : '0;
`endif
        if (r_s1_mant == '0) begin
            w_n_zero = 1'b1;
            w_n_lzc  = LZC_W'(MANT_W);
        end else if (w_exp_ext > w_lzc_ext) begin
            w_n_mant = r_s1_mant << r_s1_lzc;
            w_n_exp  = r_s1_exp - EXP_W'(r_s1_lzc);
            w_n_lzc  = r_s1_lzc;
        end else begin
`ifdef NORM_DENORM_EN
            // Shift only as far as the exponent allows and leave a denormal
            w_n_mant = r_s1_mant << w_dn_shift;
            w_n_lzc  = w_dn_shift;
`else
            w_n_zero = 1'b1;
`endif
        end
    end

    // Stage 2: output registers, held while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_mant <= '0;
            r_out_exp  <= '0;
            r_out_sign <= 1'b0;
            r_out_zero <= 1'b0;
            r_out_lzc  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_mant <= w_n_mant;
                r_out_exp  <= w_n_exp;
                r_out_sign <= r_s1_sign;
                r_out_zero <= w_n_zero;
                r_out_lzc  <= w_n_lzc;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_mant  = r_out_mant;
    assign bus.out_exp   = r_out_exp;
    assign bus.out_sign  = r_out_sign;
    assign bus.out_zero  = r_out_zero;
    assign bus.out_lzc   = r_out_lzc;
endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed bench for mantissa_normalizer: single vectors, underflow edges, backpressure, reset.
module tb_mantissa_normalizer;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned LZC_W  = 5;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    mantissa_normalizer_if #(.MANT_W(MANT_W), .EXP_W(EXP_W), .LZC_W(LZC_W)) bus ();

    mantissa_normalizer #(.MANT_W(MANT_W), .EXP_W(EXP_W), .LZC_W(LZC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // One transaction through an empty pipe, checking latency and all result fields
    task automatic single(input string tag,
                          input logic [23:0] mant, input logic [7:0] ex, input logic sgn,
                          input logic [23:0] e_mant, input logic [7:0] e_exp, input logic e_sign,
                          input logic e_zero, input logic [4:0] e_lzc);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_mant   = mant;
        bus.in_exp    = ex;
        bus.in_sign   = sgn;
        bus.out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".lat1_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".mant"}, 32'(bus.out_mant), 32'(e_mant));
        check({tag, ".exp"},  32'(bus.out_exp),  32'(e_exp));
        check({tag, ".sign"}, 32'(bus.out_sign), 32'(e_sign));
        check({tag, ".zero"}, 32'(bus.out_zero), 32'(e_zero));
        check({tag, ".lzc"},  32'(bus.out_lzc),  32'(e_lzc));
    endtask

    logic [23:0] s_mant [4];
    logic [7:0]  s_exp  [4];
    logic        s_sign [4];
    logic [23:0] x_mant [4];
    logic [7:0]  x_exp  [4];
    logic [4:0]  x_lzc  [4];
    logic [23:0] snap_mant;
    logic [7:0]  snap_exp;
    logic [4:0]  snap_lzc;
    int          sent;
    int          got;
    logic        stale;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mant = '0;
        bus.in_exp = '0;
        bus.in_sign = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_mant",  32'(bus.out_mant),  32'd0);
        check("rst.out_lzc",   32'(bus.out_lzc),   32'd0);
        rst_n = 1'b1;

        single("normal", 24'h001234, 8'h80, 1'b0, 24'h91A000, 8'h75, 1'b0, 1'b0, 5'd11);
        single("already", 24'h800001, 8'h01, 1'b1, 24'h800001, 8'h01, 1'b1, 1'b0, 5'd0);
        single("zero", 24'h000000, 8'h7F, 1'b1, 24'h000000, 8'h00, 1'b1, 1'b1, 5'd24);
        single("exp_eq_lzc_p1", 24'h001234, 8'd12, 1'b0, 24'h91A000, 8'h01, 1'b0, 1'b0, 5'd11);
`ifdef NORM_DENORM_EN
        single("underflow", 24'h000100, 8'h05, 1'b0, 24'h001000, 8'h00, 1'b0, 1'b0, 5'd4);
        single("exp_eq_lzc", 24'h001234, 8'd11, 1'b1, 24'h48D000, 8'h00, 1'b1, 1'b0, 5'd10);
        single("exp_zero", 24'h000100, 8'h00, 1'b0, 24'h000100, 8'h00, 1'b0, 1'b0, 5'd0);
`else
        single("underflow", 24'h000100, 8'h05, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 5'd0);
        single("exp_eq_lzc", 24'h001234, 8'd11, 1'b1, 24'h000000, 8'h00, 1'b1, 1'b1, 5'd0);
        single("exp_zero", 24'h000100, 8'h00, 1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 5'd0);
`endif

        // Backpressure: four back-to-back inputs, out_ready low for cycles 1..3
        s_mant[0] = 24'h400000; s_exp[0] = 8'h10; s_sign[0] = 1'b0;
        x_mant[0] = 24'h800000; x_exp[0] = 8'h0F; x_lzc[0] = 5'd1;
        s_mant[1] = 24'h000001; s_exp[1] = 8'h40; s_sign[1] = 1'b1;
        x_mant[1] = 24'h800000; x_exp[1] = 8'h29; x_lzc[1] = 5'd23;
        s_mant[2] = 24'h0F0F0F; s_exp[2] = 8'h20; s_sign[2] = 1'b0;
        x_mant[2] = 24'hF0F0F0; x_exp[2] = 8'h1C; x_lzc[2] = 5'd4;
        s_mant[3] = 24'h3ABCDE; s_exp[3] = 8'hFF; s_sign[3] = 1'b1;
        x_mant[3] = 24'hEAF378; x_exp[3] = 8'hFD; x_lzc[3] = 5'd2;
        sent = 0;
        got = 0;
        snap_mant = '0;
        snap_exp = '0;
        snap_lzc = '0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 1 && c <= 3);
            bus.in_valid  = (sent < 4);
            if (sent < 4) begin
                bus.in_mant = s_mant[sent];
                bus.in_exp  = s_exp[sent];
                bus.in_sign = s_sign[sent];
            end
            #1;
            if (c == 2) begin
                check("bp.in_ready_full", 32'(bus.in_ready), 32'd0);
                check("bp.stall_valid", 32'(bus.out_valid), 32'd1);
                snap_mant = bus.out_mant;
                snap_exp  = bus.out_exp;
                snap_lzc  = bus.out_lzc;
            end
            if (c == 3) begin
                check("bp.in_ready_held", 32'(bus.in_ready), 32'd0);
                check("bp.stable_mant", 32'(bus.out_mant), 32'(snap_mant));
                check("bp.stable_exp",  32'(bus.out_exp),  32'(snap_exp));
                check("bp.stable_lzc",  32'(bus.out_lzc),  32'(snap_lzc));
            end
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("bp.mant%0d", got), 32'(bus.out_mant), 32'(x_mant[got]));
                check($sformatf("bp.exp%0d", got),  32'(bus.out_exp),  32'(x_exp[got]));
                check($sformatf("bp.sign%0d", got), 32'(bus.out_sign), 32'(s_sign[got]));
                check($sformatf("bp.lzc%0d", got),  32'(bus.out_lzc),  32'(x_lzc[got]));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        check("bp.got_all", 32'(got), 32'd4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp.no_dup", 32'(bus.out_valid), 32'd0);

        // Reset with both stages occupied
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mant   = 24'h00F000;
        bus.in_exp    = 8'h40;
        bus.in_sign   = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst.both_full", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst.out_mant",  32'(bus.out_mant),  32'd0);
        check("mrst.out_exp",   32'(bus.out_exp),   32'd0);
        check("mrst.out_sign",  32'(bus.out_sign),  32'd0);
        check("mrst.out_zero",  32'(bus.out_zero),  32'd0);
        check("mrst.out_lzc",   32'(bus.out_lzc),   32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        check("mrst.no_stale", 32'(stale), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mantissa_normalizer.md
Name: mantissa_normalizer

Overview:
- Left-shift normalizer for the Vector ALU floating-point datapath; the counterpart of the alignment right shifter.
- Takes an un-normalized mantissa and exponent from the adder result stage.
- Counts leading zeros, shifts the mantissa left until the MSB is 1, and lowers the exponent by the shift amount.
- Two-stage valid/ready pipeline, throughput one result per cycle, between the adder and the rounding stage.

Parameters:
MANT_W, 24, mantissa width including hidden bit
EXP_W, 8, biased exponent width
LZC_W, 5, leading-zero-count width; must be at least clog2(MANT_W+1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream result valid
in_ready  output  1  block can accept input this cycle
in_mant  input  MANT_W  un-normalized mantissa
in_exp  input  EXP_W  biased exponent before normalization
in_sign  input  1  sign, passed through
out_valid  output  1  normalized result valid
out_ready  input  1  downstream accepts result
out_mant  output  MANT_W  normalized mantissa
out_exp  output  EXP_W  adjusted biased exponent
out_sign  output  1  sign
out_zero  output  1  result is zero (input zero or flushed)
out_lzc  output  LZC_W  shift amount actually applied

Behaviour:
- Reset (rst_n low at a clock edge):
  - s1_valid, s2_valid and out_valid go to 0.
  - All data registers go to 0, so out_mant, out_exp, out_sign, out_zero and out_lzc are 0.
  - Any in-flight data is discarded; nothing is emitted after reset is released.
- Stage 1 on accept:
  - Registers mant, exp and sign.
  - Registers lzc = number of leading zeros of in_mant, range 0..MANT_W; an all-zero mantissa gives lzc = MANT_W.
- Stage 2 computes from the stage-1 registers and holds all outputs in registers:
  - mant == 0: out_mant=0, out_exp=0, out_zero=1, out_lzc=MANT_W.
  - exp > lzc: out_mant = mant << lzc (zero-filled), out_exp = exp − lzc, out_zero=0, out_lzc=lzc.
  - exp <= lzc (underflow): handled according to the Optional Feature section.
- Handshake:
  - Transfers occur on valid && ready at the clock edge.
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = !s1_valid || (s2 advance); this is combinational from out_ready, with no skid buffer.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Latency and throughput:
  - Two cycles from input accept to out_valid when out_ready is held high.
  - Full throughput, one result per cycle.
- Simultaneous events: a stage may accept new data and hand off its old data in the same cycle.

Optional Feature:
Macro NORM_DENORM_EN selects the underflow behaviour (exp <= lzc).
- Defined (gradual underflow):
  - Shift = exp−1 when exp>=1, else 0.
  - out_mant = mant << shift, out_exp = 0, out_lzc = shift, out_zero = 0.
- Undefined (flush to zero): out_mant=0, out_exp=0, out_zero=1, out_lzc=0.

Test Plan:
- Normal shift: mant=0x001234, exp=0x80 -> after 2 cycles out_mant=0x91A000, out_exp=0x75, out_lzc=11, out_zero=0.
- Already normalized: mant=0x800001, exp=0x01 -> out_mant=0x800001, out_exp=0x01, out_lzc=0.
- Zero input: mant=0x000000, exp=0x7F, sign=1 -> out_zero=1, out_mant=0, out_exp=0, out_sign=1, out_lzc=24.
- Underflow: mant=0x000100, exp=0x05.
  - With NORM_DENORM_EN: out_mant=0x001000, out_exp=0, out_lzc=4.
  - Without it: out_zero=1, out_mant=0.
- Backpressure: stream 4 back-to-back inputs, hold out_ready=0 for 3 cycles.
  - in_ready drops once both stages are full.
  - out_* stay stable while stalled.
  - All 4 results emerge in order once out_ready is released, with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with both stages valid -> next cycle out_valid=0 and all outputs 0; no stale result appears after release.
